freq_meter_core: RTL and testbench

- Gated-window frequency counter; the measurement engine inside the example_top design.
- Counts rising edges of one monitored signal over a fixed window of sys-clock cycles.
- Results feed directly downstream to the UART report stage over a valid/ready handshake.
- Single clock domain; the monitored signal is asynchronous and is synchronized internally.

---
 rtl/freq_meter_core.sv | 147 ++++++++++++++
 tb/tb_freq_meter_core.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter_core.sv
// freq_meter_core: gated-window frequency counter.
// Counts synchronized rising edges of sig_i over GATE_CYCLES clk cycles.
// Ports:
//   clk, rst          system clock, async active-high reset
//   en_i              measurement enable (level)
//   sig_i             monitored signal, asynchronous to clk
//   freq_o            edge count of last completed window
//   freq_valid_o      result available, held until freq_ready_i
//   freq_ready_i      downstream accepts result
//   freq_ovf_o        last result saturated
//   freq_lost_o       sticky: unread result overwritten
//   lost_clr_i        synchronous clear of freq_lost_o
//   busy_o            window in progress
module freq_meter_core #(
    parameter int GATE_CYCLES = 123750000,
    parameter int CNT_W       = 29,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             sig_i,
    output logic [CNT_W-1:0] freq_o,
    output logic             freq_valid_o,
    input  logic             freq_ready_i,
    output logic             freq_ovf_o,
    output logic             freq_lost_o,
    input  logic             lost_clr_i,
    output logic             busy_o
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] G_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int PW = $clog2(SYNC_STAGES + 1);
    localparam logic [PW-1:0] P_DONE = PW'(SYNC_STAGES);

    typedef enum logic {
        IDLE,
        GATE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [PW-1:0]          prime_cnt;
    logic                   primed;
    logic [GW-1:0]          gate_cnt;
    logic [CNT_W-1:0]       edge_cnt;
    logic                   ovf_q;

    logic             rise;
    logic             cnt_sat;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             last;
    logic             xfer;

    // primed masks the edge detector until prev_q holds a real sample,
    // so a signal already high at reset release is not seen as a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            prime_cnt <= '0;
            primed    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            if (!primed) begin
                if (prime_cnt == P_DONE) begin
                    primed <= 1'b1;
                end
                prime_cnt <= prime_cnt + 1'b1;
            end
        end
    end

    assign rise    = sync_q[SYNC_STAGES-1] & ~prev_q & primed;
    assign cnt_sat = (edge_cnt == CNT_MAX);
    assign cnt_nxt = (rise && !cnt_sat) ? edge_cnt + 1'b1 : edge_cnt;
    assign ovf_nxt = ovf_q | (rise & cnt_sat);
    assign last    = (state == GATE) && (gate_cnt == G_LAST);
    assign xfer    = freq_valid_o & freq_ready_i;

    // The last window cycle folds its own edge into the published result
    // and restarts the counters, so back-to-back windows share no cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            gate_cnt     <= '0;
            edge_cnt     <= '0;
            ovf_q        <= 1'b0;
            freq_o       <= '0;
            freq_ovf_o   <= 1'b0;
            freq_valid_o <= 1'b0;
            freq_lost_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    ovf_q    <= 1'b0;
                    if (en_i) begin
                        state  <= GATE;
                        busy_o <= 1'b1;
                    end
                end
                GATE: begin
                    if (last || !en_i) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf_q    <= 1'b0;
                        if (!en_i) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                        edge_cnt <= cnt_nxt;
                        ovf_q    <= ovf_nxt;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase

            if (last) begin
                freq_o       <= cnt_nxt;
                freq_ovf_o   <= ovf_nxt;
                freq_valid_o <= 1'b1;
            end else if (xfer) begin
                freq_valid_o <= 1'b0;
            end

            if (last && freq_valid_o && !freq_ready_i) begin
                freq_lost_o <= 1'b1;
            end else if (lost_clr_i) begin
                freq_lost_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter_core.sv
// tb_freq_meter_core: directed scenarios plus randomized traffic,
// checked every cycle against an unbounded-count window model.
`timescale 1ns/100ps
module tb_freq_meter_core;

    localparam int G  = 100;
    localparam int CW = 4;
    localparam int S  = 2;
    localparam longint MAXV = (64'd1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_i = 1'b0;
    logic freq_ready_i = 1'b0;
    logic lost_clr_i = 1'b0;
    logic sig_lvl = 1'b0;
    logic sq = 1'b0;
    logic sig_async = 1'b0;
    logic async_on = 1'b0;
    int   per = 0;
    int   ph = 0;
    logic sig_i;

    logic [CW-1:0] freq_o;
    logic freq_valid_o, freq_ovf_o, freq_lost_o, busy_o;

    int n_chk = 0;
    int n_fail = 0;

    assign sig_i = async_on ? sig_async : ((per == 0) ? sig_lvl : sq);

    freq_meter_core #(
        .GATE_CYCLES(G),
        .CNT_W(CW),
        .SYNC_STAGES(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en_i(en_i),
        .sig_i(sig_i),
        .freq_o(freq_o),
        .freq_valid_o(freq_valid_o),
        .freq_ready_i(freq_ready_i),
        .freq_ovf_o(freq_ovf_o),
        .freq_lost_o(freq_lost_o),
        .lost_clr_i(lost_clr_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Asynchronous source, period 73 ns = 7.3 clk, offset off the clock grid.
    initial begin
        #0.3;
        forever #36.5 sig_async = ~sig_async;
    end

    always @(negedge clk) begin
        if (per != 0) begin
            ph = (ph + 1 >= per) ? 0 : ph + 1;
            sq = (ph < per / 2);
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: windows counted as unbounded integers,
    // clamped only when published.
    bit     q[$];
    bit     mdl_active;
    int     mdl_k;
    longint mdl_cnt;
    bit     exp_valid, exp_ovf, exp_lost;
    longint exp_freq;
    bit     m_pub, m_e, m_xfer;
    longint m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            mdl_active = 0;
            mdl_k = 0;
            mdl_cnt = 0;
            exp_valid = 0;
            exp_ovf = 0;
            exp_lost = 0;
            exp_freq = 0;
        end else begin
            m_pub = 0;
            m_res = 0;
            q.push_back(sig_i);
            if (q.size() > S + 2) void'(q.pop_front());
            m_e = (q.size() == S + 2) && q[1] && !q[0];
            m_xfer = exp_valid && freq_ready_i;
            if (!mdl_active) begin
                if (en_i) begin
                    mdl_active = 1;
                    mdl_k = 0;
                    mdl_cnt = 0;
                end
            end else if (mdl_k == G - 1) begin
                m_pub = 1;
                m_res = mdl_cnt + longint'(m_e);
                mdl_k = 0;
                mdl_cnt = 0;
                if (!en_i) mdl_active = 0;
            end else if (!en_i) begin
                mdl_active = 0;
            end else begin
                mdl_cnt += longint'(m_e);
                mdl_k++;
            end
            if (m_pub && exp_valid && !freq_ready_i) exp_lost = 1;
            else if (lost_clr_i) exp_lost = 0;
            if (m_pub) begin
                exp_valid = 1;
                exp_freq = (m_res > MAXV) ? MAXV : m_res;
                exp_ovf = (m_res > MAXV);
            end else if (m_xfer) begin
                exp_valid = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("valid", freq_valid_o, exp_valid);
        chk("busy", busy_o, mdl_active);
        chk("lost", freq_lost_o, exp_lost);
        if (exp_valid) begin
            chk("freq", freq_o, exp_freq);
            chk("ovf", freq_ovf_o, exp_ovf);
        end
    end

    task automatic wait_pub(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!freq_valid_o && n < 300);
        if (!freq_valid_o) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_pub: no valid within %0d cycles", n);
        end
    endtask

    task automatic wait_k(input int k);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!(mdl_active && mdl_k == k) && i < 300);
        if (!(mdl_active && mdl_k == k)) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_k: window pos %0d not reached, at %0d", k, mdl_k);
        end
    endtask

    int n;
    int rdy_pct;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", freq_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_freq", freq_o, 0);
        chk("rst_lost", freq_lost_o, 0);
        rst = 1'b0;
        per = 10;
        repeat (10) @(negedge clk);

        // Square wave, period 10
        freq_ready_i = 1'b1;
        en_i = 1'b1;
        wait_pub(n);
        chk("t1_latency", n, 101);
        chk("t1_freq", freq_o, 10);
        chk("t1_ovf", freq_ovf_o, 0);
        wait_pub(n);
        chk("t1_gap", n, 100);
        chk("t1_freq2", freq_o, 10);

        // Period 4 -> 25 edges saturate at 15
        per = 4;
        wait_pub(n);
        wait_pub(n);
        chk("t2_freq", freq_o, 15);
        chk("t2_ovf", freq_ovf_o, 1);

        // Unread results overwritten
        per = 10;
        wait_pub(n);
        @(negedge clk);
        freq_ready_i = 1'b0;
        repeat (310) @(negedge clk);
        chk("t3_valid", freq_valid_o, 1);
        chk("t3_freq", freq_o, 10);
        chk("t3_lost", freq_lost_o, 1);
        wait_k(50);
        lost_clr_i = 1'b1;
        @(negedge clk);
        lost_clr_i = 1'b0;
        chk("t3_clr", freq_lost_o, 0);
        freq_ready_i = 1'b1;

        // Abort mid-window
        repeat (5) @(negedge clk);
        wait_k(50);
        en_i = 1'b0;
        @(posedge clk);
        #1;
        chk("t4_busy", busy_o, 0);
        chk("t4_valid", freq_valid_o, 0);
        repeat (20) @(negedge clk);
        chk("t4_idle_valid", freq_valid_o, 0);
        en_i = 1'b1;
        wait_pub(n);
        chk("t4_latency", n, 101);
        chk("t4_freq", freq_o, 10);

        // High through reset, then one edge on the last window cycle
        @(negedge clk);
        rst = 1'b1;
        per = 0;
        sig_lvl = 1'b1;
        en_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_rst_valid", freq_valid_o, 0);
        chk("t5_rst_busy", busy_o, 0);
        rst = 1'b0;
        en_i = 1'b1;
        wait_pub(n);
        chk("t5_latency", n, 101);
        chk("t5_freq0", freq_o, 0);
        @(negedge clk);
        sig_lvl = 1'b0;
        wait_k(G - 3);
        sig_lvl = 1'b1;
        wait_pub(n);
        chk("t5_last_edge", freq_o, 1);
        wait_pub(n);
        chk("t5_next_win", freq_o, 0);

        // Async input, ready coincident with publish
        async_on = 1'b1;
        repeat (120) @(negedge clk);
        freq_ready_i = 1'b0;
        wait_pub(n);
        wait_k(G - 1);
        freq_ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_valid", freq_valid_o, 1);
        chk("t6_lost", freq_lost_o, 0);
        n_chk++;
        if (freq_o < 13 || freq_o > 14) begin
            n_fail++;
            $display("FAIL t6_range: got %0d, expected 13..14", freq_o);
        end
        @(negedge clk);
        freq_ready_i = 1'b0;

        // Randomized traffic
        async_on = 1'b0;
        rdy_pct = 5;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (i % 200 == 0) rdy_pct = $urandom_range(0, 10);
            sig_lvl = 1'($urandom);
            freq_ready_i = ($urandom_range(0, 9) < rdy_pct);
            lost_clr_i = ($urandom_range(0, 49) == 0);
            if (en_i && $urandom_range(0, 299) == 0) en_i = 1'b0;
            else if (!en_i && $urandom_range(0, 4) == 0) en_i = 1'b1;
        end
        @(negedge clk);
        lost_clr_i = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
